// File: rtl/vscale_hpm_counters_if.sv
// Host (HTIF-style) register request/response channel of the vscale HPM counter bank.
interface vscale_hpm_counters_if #(
  parameter int unsigned XPR_LEN = 32
);
  logic               host_req_valid;
  logic               host_req_ready;
  logic               host_req_rw;
  logic [11:0]        host_req_addr;
  logic [XPR_LEN-1:0] host_req_data;
  logic               host_resp_valid;
  logic               host_resp_ready;
  logic [XPR_LEN-1:0] host_resp_data;

  modport master (
    output host_req_valid, host_req_rw, host_req_addr, host_req_data, host_resp_ready,
    input  host_req_ready, host_resp_valid, host_resp_data
  );

  modport slave (
    input  host_req_valid, host_req_rw, host_req_addr, host_req_data, host_resp_ready,
    output host_req_ready, host_resp_valid, host_resp_data
  );
endinterface

// File: rtl/vscale_hpm_counters.sv
// Hardware performance-monitor counter bank for vscale, served by core CSR ops and a host port.
// Optional `VSCALE_HPM_SNAPSHOT_EN: low-half reads latch a per-counter high-half shadow.
module vscale_hpm_counters #(
  parameter int unsigned XPR_LEN       = 32,
  parameter int unsigned NUM_COUNTERS  = 4,
  parameter int unsigned COUNTER_WIDTH = 64,
  parameter int unsigned NUM_EVENTS    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [11:0]             csr_addr,
  input  logic [2:0]              csr_cmd,
  input  logic [XPR_LEN-1:0]      csr_wdata,
  output logic [XPR_LEN-1:0]      csr_rdata,
  output logic                    csr_hit,
  input  logic [NUM_EVENTS-1:0]   events,
  output logic                    overflow_irq,
  vscale_hpm_counters_if.slave    host
);
  localparam int unsigned EVW = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;
  localparam int unsigned HW  = COUNTER_WIDTH - 32;

  typedef enum logic [0:0] {StIdle, StWait} host_state_e;

  logic [COUNTER_WIDTH-1:0] cnt_q   [NUM_COUNTERS];
  logic [EVW-1:0]           evsel_q [NUM_COUNTERS];
  logic [HW-1:0]            hi_view [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0]  inhibit_q, ovf_q, ovf_en_q, inc, wrap, cnt_wr, ovf_clr;

  host_state_e        state_q;
  logic               resp_valid_q;
  logic [XPR_LEN-1:0] resp_data_q;

  function automatic logic [11:0] lo_addr(input int unsigned i);
    return 12'hB03 + 12'(i);
  endfunction

  function automatic logic [11:0] hi_addr(input int unsigned i);
    return 12'hB83 + 12'(i);
  endfunction

  function automatic logic [11:0] ev_addr(input int unsigned i);
    return 12'h323 + 12'(i);
  endfunction

  function automatic logic reg_hit(input logic [11:0] addr);
    logic hit;
    hit = (addr == 12'h320) || (addr == 12'h7C0) || (addr == 12'h7C1);
    for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
      hit |= (addr == lo_addr(i)) || (addr == hi_addr(i)) || (addr == ev_addr(i));
    end
    return hit;
  endfunction

  function automatic logic [XPR_LEN-1:0] reg_data(input logic [11:0] addr);
    logic [XPR_LEN-1:0] data;
    data = '0;
    if (addr == 12'h320) data = XPR_LEN'({inhibit_q, 3'b000});
    if (addr == 12'h7C0) data = XPR_LEN'({ovf_q, 3'b000});
    if (addr == 12'h7C1) data = XPR_LEN'({ovf_en_q, 3'b000});
    for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
      if (addr == lo_addr(i)) data = XPR_LEN'(cnt_q[i][31:0]);
      if (addr == hi_addr(i)) data = XPR_LEN'(hi_view[i]);
      if (addr == ev_addr(i)) data = XPR_LEN'(evsel_q[i]);
    end
    return data;
  endfunction

  logic               core_wr, host_acc, wr_en;
  logic [11:0]        wr_addr;
  logic [XPR_LEN-1:0] core_wdata, wr_data, wr_raw, host_rd;

  assign csr_hit   = reg_hit(csr_addr);
  assign csr_rdata = reg_data(csr_addr);
  assign host_rd   = reg_data(host.host_req_addr);
  assign core_wr   = csr_cmd[2] & (csr_cmd[1] | csr_cmd[0]);

  always_comb begin
    core_wdata = csr_wdata;
    unique case (csr_cmd[1:0])
      2'b10:   core_wdata = csr_rdata | csr_wdata;
      2'b11:   core_wdata = csr_rdata & ~csr_wdata;
      default: core_wdata = csr_wdata;
    endcase
  end

  // Host and core never write together: the host is held off while a core write is present.
  assign host.host_req_ready = (state_q == StIdle) && !core_wr;
  assign host_acc            = host.host_req_valid && host.host_req_ready;
  assign wr_en               = core_wr || (host_acc && host.host_req_rw);
  assign wr_addr             = core_wr ? csr_addr : host.host_req_addr;
  assign wr_data             = core_wr ? core_wdata : host.host_req_data;
  assign wr_raw              = core_wr ? csr_wdata : host.host_req_data;

  always_comb begin
    inc     = '0;
    wrap    = '0;
    cnt_wr  = '0;
    ovf_clr = '0;
    // ovf is W1C on raw write data; a core clear command leaves it alone
    if (wr_en && wr_addr == 12'h7C0 && !(core_wr && csr_cmd[1:0] == 2'b11)) begin
      ovf_clr = wr_raw[NUM_COUNTERS+2:3];
    end
    for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
      cnt_wr[i] = wr_en && (wr_addr == lo_addr(i) || wr_addr == hi_addr(i));
      inc[i]    = !inhibit_q[i] && (32'(evsel_q[i]) < NUM_EVENTS) && events[evsel_q[i]] &&
                  !cnt_wr[i];
      wrap[i]   = inc[i] && (&cnt_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
        cnt_q[i]   <= '0;
        evsel_q[i] <= '0;
      end
      inhibit_q <= '1;
      ovf_q     <= '0;
      ovf_en_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
        if (wr_en && wr_addr == lo_addr(i)) begin
          cnt_q[i][31:0] <= wr_data[31:0];
        end else if (wr_en && wr_addr == hi_addr(i)) begin
          cnt_q[i][COUNTER_WIDTH-1:32] <= wr_data[HW-1:0];
        end else if (inc[i]) begin
          cnt_q[i] <= cnt_q[i] + COUNTER_WIDTH'(1);
        end
        if (wr_en && wr_addr == ev_addr(i)) evsel_q[i] <= wr_data[EVW-1:0];
      end
      if (wr_en && wr_addr == 12'h320) inhibit_q <= wr_data[NUM_COUNTERS+2:3];
      if (wr_en && wr_addr == 12'h7C1) ovf_en_q  <= wr_data[NUM_COUNTERS+2:3];
      // A wrap in the same cycle as a W1C keeps the flag set
      ovf_q <= (ovf_q & ~ovf_clr) | wrap;
    end
  end

  assign overflow_irq = |(ovf_q & ovf_en_q);

`ifdef VSCALE_HPM_SNAPSHOT_EN
  logic [HW-1:0] shadow_q [NUM_COUNTERS];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
      if (reset) begin
        shadow_q[i] <= '0;
      end else if (wr_en && wr_addr == lo_addr(i)) begin
        shadow_q[i] <= cnt_q[i][COUNTER_WIDTH-1:32];
      end else if (wr_en && wr_addr == hi_addr(i)) begin
        shadow_q[i] <= wr_data[HW-1:0];
      end else if ((csr_cmd[2] && csr_addr == lo_addr(i)) ||
                   (host_acc && host.host_req_addr == lo_addr(i))) begin
        shadow_q[i] <= cnt_q[i][COUNTER_WIDTH-1:32];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_COUNTERS; i++) hi_view[i] = shadow_q[i];
  end
`else
  always_comb begin
    for (int unsigned i = 0; i < NUM_COUNTERS; i++) hi_view[i] = cnt_q[i][COUNTER_WIDTH-1:32];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (host_acc) begin
            state_q      <= StWait;
            resp_valid_q <= 1'b1;
            resp_data_q  <= host_rd;
          end
        end
        StWait: begin
          if (host.host_resp_ready) begin
            state_q      <= StIdle;
            resp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= StIdle;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign host.host_resp_valid = resp_valid_q;
  assign host.host_resp_data  = resp_data_q;
endmodule

// File: tb/tb_vscale_hpm_counters.sv
// Self-checking bench for vscale_hpm_counters: directed scenarios plus randomised traffic
// compared against a register-level behavioural model.
`timescale 1ns/1ps
module tb_vscale_hpm_counters;
  localparam int NC = 4;
`ifdef VSCALE_HPM_SNAPSHOT_EN
  localparam bit SnapEn = 1'b1;
`else
  localparam bit SnapEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] csr_addr = '0;
  logic [2:0]  csr_cmd = '0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic        csr_hit;
  logic [7:0]  events = '0;
  logic        overflow_irq;

  vscale_hpm_counters_if #(.XPR_LEN(32)) host_if ();

  vscale_hpm_counters #(
    .XPR_LEN(32), .NUM_COUNTERS(NC), .COUNTER_WIDTH(64), .NUM_EVENTS(8)
  ) dut (
    .clk(clk), .reset(reset), .csr_addr(csr_addr), .csr_cmd(csr_cmd), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_hit(csr_hit), .events(events), .overflow_irq(overflow_irq),
    .host(host_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model: one entry per architectural register field.
  logic [63:0] m_cnt [NC];
  logic [31:0] m_shadow [NC];
  int          m_evsel [NC];
  bit          m_inh [NC];
  bit          m_ovf [NC];
  bit          m_ovfen [NC];

  task automatic m_reset();
    for (int i = 0; i < NC; i++) begin
      m_cnt[i] = '0; m_shadow[i] = '0; m_evsel[i] = 0;
      m_inh[i] = 1'b1; m_ovf[i] = 1'b0; m_ovfen[i] = 1'b0;
    end
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < NC; i++) begin
      if (int'(a) == 'h320) r[i+3] = m_inh[i];
      if (int'(a) == 'h7C0) r[i+3] = m_ovf[i];
      if (int'(a) == 'h7C1) r[i+3] = m_ovfen[i];
    end
    for (int i = 0; i < NC; i++) begin
      if (int'(a) == 'hB03 + i) r = m_cnt[i][31:0];
      if (int'(a) == 'hB83 + i) r = SnapEn ? m_shadow[i] : m_cnt[i][63:32];
      if (int'(a) == 'h323 + i) r = 32'(m_evsel[i]);
    end
    return r;
  endfunction

  function automatic bit m_irq();
    bit r;
    r = 1'b0;
    for (int i = 0; i < NC; i++) r |= m_ovf[i] & m_ovfen[i];
    return r;
  endfunction

  // One clock of the architecture: optional write (kind 5/6/7), optional read, event vector.
  task automatic m_apply(input bit wr, input logic [2:0] kind, input logic [11:0] wa,
                         input logic [31:0] wd, input bit rd, input logic [11:0] ra,
                         input logic [7:0] ev);
    logic [31:0] eff;
    bit skip [NC];
    eff = (kind == 3'd6) ? (m_read(wa) | wd) : (kind == 3'd7) ? (m_read(wa) & ~wd) : wd;
    for (int i = 0; i < NC; i++) begin
      skip[i] = wr && (int'(wa) == 'hB03 + i || int'(wa) == 'hB83 + i);
      if (rd && int'(ra) == 'hB03 + i) m_shadow[i] = m_cnt[i][63:32];
    end
    if (wr && int'(wa) == 'h7C0 && kind != 3'd7)
      for (int i = 0; i < NC; i++) if (wd[i+3]) m_ovf[i] = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (!skip[i] && !m_inh[i] && m_evsel[i] < 8 && ev[m_evsel[i]]) begin
        if (m_cnt[i] == '1) m_ovf[i] = 1'b1;
        m_cnt[i] = m_cnt[i] + 64'd1;
      end
    end
    if (wr) begin
      for (int i = 0; i < NC; i++) begin
        if (int'(wa) == 'h320) m_inh[i] = eff[i+3];
        if (int'(wa) == 'h7C1) m_ovfen[i] = eff[i+3];
        if (int'(wa) == 'h323 + i) m_evsel[i] = int'(eff[2:0]);
        if (int'(wa) == 'hB03 + i) begin
          m_cnt[i][31:0] = eff; m_shadow[i] = m_cnt[i][63:32];
        end
        if (int'(wa) == 'hB83 + i) begin
          m_cnt[i][63:32] = eff; m_shadow[i] = eff;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_op(input logic [2:0] cmd, input logic [11:0] a, input logic [31:0] d,
                         input logic [7:0] ev);
    csr_cmd = cmd; csr_addr = a; csr_wdata = d; events = ev;
    m_apply(cmd[2] && (cmd[1] || cmd[0]), cmd, a, d, cmd[2], a, ev);
    tick();
    csr_cmd = '0; events = '0;
  endtask

  task automatic idle(input logic [7:0] ev);
    events = ev;
    m_apply(1'b0, 3'd0, 12'h0, 32'h0, 1'b0, 12'h0, ev);
    tick();
    events = '0;
  endtask

  // Complete host transfer with resp_ready high; ok=0 if never accepted or no response.
  task automatic host_xfer(input bit rw, input logic [11:0] a, input logic [31:0] d,
                           output logic [31:0] resp, output logic [31:0] expv, output bit ok);
    int n;
    n = 0;
    host_if.host_req_valid = 1'b1; host_if.host_req_rw = rw;
    host_if.host_req_addr = a; host_if.host_req_data = d; host_if.host_resp_ready = 1'b1;
    #1;
    while (host_if.host_req_ready !== 1'b1 && n < 20) begin
      idle(8'h0);
      n++;
    end
    expv = m_read(a);
    ok = (n < 20);
    if (ok) begin
      m_apply(rw, 3'd5, a, d, 1'b1, a, 8'h0);
      tick();
    end
    host_if.host_req_valid = 1'b0;
    resp = host_if.host_resp_data;
    ok = ok && (host_if.host_resp_valid === 1'b1);
    idle(8'h0);
  endtask

  function automatic logic [11:0] pick_addr();
    case ($urandom_range(0, 6))
      0:       return 12'h320;
      1:       return 12'h7C0;
      2:       return 12'h7C1;
      3:       return 12'('hB03 + $urandom_range(0, 4));
      4:       return 12'('hB83 + $urandom_range(0, 4));
      5:       return 12'('h323 + $urandom_range(0, 4));
      default: return 12'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    m_reset();
    csr_addr = 12'h320; #1;
    checks++; if (csr_rdata !== 32'h78) begin
      failures++; $display("FAIL reset_inhibit got=%h exp=%h", csr_rdata, 32'h78); end
    csr_addr = 12'hB03; #1;
    checks++; if (csr_rdata !== 32'h0 || csr_hit !== 1'b1) begin
      failures++; $display("FAIL reset_cnt0 got=%h hit=%b exp=0 hit=1", csr_rdata, csr_hit); end
    csr_addr = 12'hB07; #1;
    checks++; if (csr_rdata !== 32'h0 || csr_hit !== 1'b0) begin
      failures++; $display("FAIL miss_addr got=%h hit=%b exp=0 hit=0", csr_rdata, csr_hit); end
    checks++; if (host_if.host_req_ready !== 1'b1 || overflow_irq !== 1'b0 ||
                  host_if.host_resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got ready=%b irq=%b rvalid=%b exp 1 0 0",
               host_if.host_req_ready, overflow_irq, host_if.host_resp_valid);
    end
  endtask

  task automatic test_count();
    core_op(3'd5, 12'h323, 32'd2, 8'h0);
    core_op(3'd7, 12'h320, 32'h8, 8'h0);
    for (int k = 0; k < 5; k++) begin
      idle(8'b0000_0110);
      idle(8'b0000_0010);
    end
    csr_addr = 12'hB03; #1;
    checks++; if (csr_rdata !== 32'd5) begin
      failures++; $display("FAIL count5 got=%0d exp=5", csr_rdata); end
    csr_addr = 12'hB04; #1;
    checks++; if (csr_rdata !== 32'd0) begin
      failures++; $display("FAIL inhibited_cnt1 got=%0d exp=0", csr_rdata); end
    csr_addr = 12'h320; #1;
    checks++; if (csr_rdata !== 32'h70) begin
      failures++; $display("FAIL inhibit_clr got=%h exp=%h", csr_rdata, 32'h70); end
  endtask

  task automatic test_overflow();
    core_op(3'd5, 12'hB83, 32'hFFFF_FFFF, 8'h0);
    core_op(3'd5, 12'hB03, 32'hFFFF_FFFE, 8'h0);
    core_op(3'd6, 12'h7C1, 32'h8, 8'h0);
    idle(8'h04);
    checks++; if (overflow_irq !== 1'b0) begin
      failures++; $display("FAIL irq_early got=%b exp=0", overflow_irq); end
    idle(8'h04);
    csr_addr = 12'hB03; #1;
    checks++; if (csr_rdata !== 32'h0) begin
      failures++; $display("FAIL wrap_lo got=%h exp=0", csr_rdata); end
    csr_addr = 12'hB83; #1;
    checks++; if (csr_rdata !== 32'h0) begin
      failures++; $display("FAIL wrap_hi got=%h exp=0", csr_rdata); end
    csr_addr = 12'h7C0; #1;
    checks++; if (csr_rdata !== 32'h8 || overflow_irq !== 1'b1) begin
      failures++; $display("FAIL ovf_set got=%h irq=%b exp=8 irq=1", csr_rdata, overflow_irq); end
    core_op(3'd7, 12'h7C0, 32'h8, 8'h0);
    csr_addr = 12'h7C0; #1;
    checks++; if (csr_rdata !== 32'h8) begin
      failures++; $display("FAIL ovf_clear_noop got=%h exp=8", csr_rdata); end
    core_op(3'd5, 12'h7C0, 32'h8, 8'h0);
    csr_addr = 12'h7C0; #1;
    checks++; if (overflow_irq !== 1'b0 || csr_rdata !== 32'h0) begin
      failures++; $display("FAIL ovf_w1c got=%h irq=%b exp=0 irq=0", csr_rdata, overflow_irq); end
  endtask

  task automatic test_write_vs_event();
    core_op(3'd5, 12'hB83, 32'h77, 8'h0);
    core_op(3'd5, 12'hB03, 32'h1234_5678, 8'h04);
    csr_addr = 12'hB03; #1;
    checks++; if (csr_rdata !== 32'h1234_5678) begin
      failures++; $display("FAIL wr_wins_lo got=%h exp=%h", csr_rdata, 32'h1234_5678); end
    csr_addr = 12'hB83; #1;
    checks++; if (csr_rdata !== 32'h77) begin
      failures++; $display("FAIL wr_wins_hi got=%h exp=%h", csr_rdata, 32'h77); end
    core_op(3'd6, 12'hB03, 32'h1, 8'h04);
    csr_addr = 12'hB03; #1;
    checks++; if (csr_rdata !== 32'h1234_5679) begin
      failures++; $display("FAIL set_wins got=%h exp=%h", csr_rdata, 32'h1234_5679); end
  endtask

  task automatic test_host_stall();
    logic [31:0] r;
    r = 32'($urandom_range(0, 7));
    core_op(3'd5, 12'h324, r, 8'h0);
    csr_cmd = 3'd5; csr_addr = 12'h325; csr_wdata = 32'd3;
    host_if.host_req_valid = 1'b1; host_if.host_req_rw = 1'b1;
    host_if.host_req_addr = 12'h324; host_if.host_req_data = 32'd5;
    host_if.host_resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (host_if.host_req_ready !== 1'b0 || host_if.host_resp_valid !== 1'b0) begin
        failures++; $display("FAIL stall got ready=%b rvalid=%b exp 0 0",
                             host_if.host_req_ready, host_if.host_resp_valid); end
      m_apply(1'b1, 3'd5, 12'h325, 32'd3, 1'b1, 12'h325, 8'h0);
      tick();
    end
    csr_cmd = '0; #1;
    checks++; if (host_if.host_req_ready !== 1'b1) begin
      failures++; $display("FAIL unstall got=%b exp=1", host_if.host_req_ready); end
    m_apply(1'b1, 3'd5, 12'h324, 32'd5, 1'b1, 12'h324, 8'h0);
    tick();
    host_if.host_req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (host_if.host_resp_valid !== 1'b1 || host_if.host_resp_data !== r) begin
        failures++; $display("FAIL resp_hold got valid=%b data=%h exp 1 %h",
                             host_if.host_resp_valid, host_if.host_resp_data, r); end
      idle(8'h0);
    end
    host_if.host_resp_ready = 1'b1;
    idle(8'h0);
    checks++; if (host_if.host_resp_valid !== 1'b0 || host_if.host_req_ready !== 1'b1) begin
      failures++; $display("FAIL resp_done got valid=%b ready=%b exp 0 1",
                           host_if.host_resp_valid, host_if.host_req_ready); end
    csr_addr = 12'h324; #1;
    checks++; if (csr_rdata !== 32'd5) begin
      failures++; $display("FAIL host_wr got=%h exp=5", csr_rdata); end
  endtask

  task automatic test_reset_in_wait();
    host_if.host_req_valid = 1'b1; host_if.host_req_rw = 1'b0;
    host_if.host_req_addr = 12'h324; host_if.host_resp_ready = 1'b0;
    tick();
    host_if.host_req_valid = 1'b0;
    checks++; if (host_if.host_resp_valid !== 1'b1) begin
      failures++; $display("FAIL wait_entry got=%b exp=1", host_if.host_resp_valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_reset();
    csr_addr = 12'h320; #1;
    checks++; if (host_if.host_resp_valid !== 1'b0 || host_if.host_resp_data !== 32'h0 ||
                  host_if.host_req_ready !== 1'b1 || csr_rdata !== 32'h78) begin
      failures++; $display("FAIL reset_wait got valid=%b data=%h ready=%b inh=%h exp 0 0 1 78",
                           host_if.host_resp_valid, host_if.host_resp_data,
                           host_if.host_req_ready, csr_rdata); end
    host_if.host_resp_ready = 1'b1;
  endtask

  task automatic test_snapshot();
    logic [31:0] expv;
    core_op(3'd5, 12'hB83, 32'h0, 8'h0);
    core_op(3'd5, 12'hB03, 32'hFFFF_FFFF, 8'h0);
    core_op(3'd5, 12'h323, 32'd2, 8'h0);
    core_op(3'd7, 12'h320, 32'h8, 8'h0);
    core_op(3'd4, 12'hB03, 32'h0, 8'h0);
    idle(8'h04);
    expv = SnapEn ? 32'h0 : 32'h1;
    csr_addr = 12'hB83; #1;
    checks++; if (csr_rdata !== expv) begin
      failures++; $display("FAIL snapshot_hi got=%h exp=%h", csr_rdata, expv); end
  endtask

  task automatic test_random();
    logic [31:0] resp, expv;
    logic [11:0] a;
    bit ok;
    for (int round = 0; round < 6; round++) begin
      for (int i = 0; i < NC; i++) begin
        core_op(3'd5, 12'('h323 + i), $urandom, 8'h0);
        core_op(3'd5, 12'('hB83 + i), ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : $urandom, 8'h0);
        core_op(3'd5, 12'('hB03 + i), 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)), 8'h0);
      end
      core_op(3'd5, 12'h320, $urandom, 8'h0);
      core_op(3'd5, 12'h7C1, $urandom, 8'h0);
      for (int c = 0; c < 40; c++) begin
        if ($urandom_range(0, 5) == 0)
          core_op(3'(4 + $urandom_range(0, 3)), pick_addr(), $urandom, 8'($urandom));
        else
          idle(8'($urandom));
        checks++; if (overflow_irq !== m_irq()) begin
          failures++; $display("FAIL rnd_irq got=%b exp=%b", overflow_irq, m_irq()); end
      end
      for (int h = 0; h < 4; h++) begin
        a = pick_addr();
        host_xfer(1'($urandom_range(0, 1)), a, $urandom, resp, expv, ok);
        checks++; if (!ok || resp !== expv) begin
          failures++; $display("FAIL rnd_host addr=%h ok=%b got=%h exp=%h", a, ok, resp, expv); end
      end
      for (int k = 0; k < 3 + 3 * NC; k++) begin
        a = (k < 3) ? ((k == 0) ? 12'h320 : (k == 1) ? 12'h7C0 : 12'h7C1)
                    : (k < 3 + NC)     ? 12'('hB03 + k - 3)
                    : (k < 3 + 2 * NC) ? 12'('hB83 + k - 3 - NC) : 12'('h323 + k - 3 - 2 * NC);
        csr_addr = a; #1;
        checks++; if (csr_rdata !== m_read(a)) begin
          failures++; $display("FAIL rnd_reg addr=%h got=%h exp=%h", a, csr_rdata, m_read(a)); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] a;
    logic [31:0] expv;
    host_if.host_req_valid = 1'b1; host_if.host_req_rw = 1'b0; host_if.host_resp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      a = 12'('h323 + (k % NC));
      host_if.host_req_addr = a; #1;
      checks++; if (host_if.host_req_ready !== 1'b1) begin
        failures++; $display("FAIL b2b_ready k=%0d got=%b exp=1", k, host_if.host_req_ready); end
      expv = m_read(a);
      m_apply(1'b0, 3'd0, 12'h0, 32'h0, 1'b1, a, 8'h0);
      tick();
      checks++; if (host_if.host_resp_valid !== 1'b1 || host_if.host_resp_data !== expv ||
                    host_if.host_req_ready !== 1'b0) begin
        failures++; $display("FAIL b2b_resp k=%0d got valid=%b data=%h ready=%b exp 1 %h 0", k,
                             host_if.host_resp_valid, host_if.host_resp_data,
                             host_if.host_req_ready, expv); end
      idle(8'h0);
    end
    host_if.host_req_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    host_if.host_req_valid = 1'b0; host_if.host_req_rw = 1'b0; host_if.host_req_addr = '0;
    host_if.host_req_data = '0; host_if.host_resp_ready = 1'b1;
    test_reset();
    test_count();
    test_overflow();
    test_write_vs_event();
    test_host_stall();
    test_reset_in_wait();
    test_snapshot();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
